// File: rtl/digpot_seq_if.sv
// rtl/digpot_seq_if.sv - command, status and pot-pin bundle for the wiper sequencer
interface digpot_seq_if #(
    parameter int WIDTH = 7
);
    logic [WIDTH-1:0] target;
    logic             load;
    logic             store;
    logic             home;
    logic             busy;
    logic             done;
    logic             err;
    logic [WIDTH-1:0] position;
    logic             pos_valid;
    logic             cs_n;
    logic             inc_n;
    logic             u_d;

    modport master (
        output target, load, store, home,
        input  busy, done, err, position, pos_valid, cs_n, inc_n, u_d
    );

    modport slave (
        input  target, load, store, home,
        output busy, done, err, position, pos_valid, cs_n, inc_n, u_d
    );
endinterface

// File: rtl/digpot_seq.sv
// rtl/digpot_seq.sv - CS/INC/U_D sequencer walking a three-wire digital pot to an absolute tap
module digpot_seq #(
    parameter int TAPS          = 100,
    parameter int WIDTH         = 7,
    parameter int PULSE_CYC     = 2,
    parameter int CS_SETUP      = 2,
    parameter int DESEL_CYC     = 3,
    parameter int HOME_ON_RESET = 1
) (
    input logic         clk,
    input logic         rst_n,
    digpot_seq_if.slave bus
);
    localparam logic [WIDTH:0]   TAPS_W   = (WIDTH + 1)'(TAPS);
    localparam logic [WIDTH-1:0] MAX_POS  = WIDTH'(TAPS - 1);
    localparam logic [15:0]      PULSE_LD = 16'(PULSE_CYC - 1);
    localparam logic [15:0]      SETUP_LD = 16'(CS_SETUP - 1);
    localparam logic [15:0]      DESEL_LD = 16'(DESEL_CYC - 1);

    typedef enum logic [2:0] {IDLE, SETUP, STEP_LO, STEP_HI, DESEL, RECOVER} state_t;

    state_t           state;
    logic [15:0]      cnt;
    logic [WIDTH-1:0] steps;
    logic [WIDTH-1:0] position_q;
    logic [WIDTH-1:0] pos_step;
    logic             store_q;
    logic             homing;
    logic             home_pend;
    logic             busy_q, done_q, err_q, pos_valid_q;
    logic             cs_n_q, inc_n_q, u_d_q;

    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.err       = err_q;
    assign bus.position  = position_q;
    assign bus.pos_valid = pos_valid_q;
    assign bus.cs_n      = cs_n_q;
    assign bus.inc_n     = inc_n_q;
    assign bus.u_d       = u_d_q;

    // Tracked position after one more wiper step, saturating at both ends (homing relies on this)
    always_comb begin
        pos_step = position_q;
        if (u_d_q) begin
            if (position_q != MAX_POS) pos_step = position_q + 1'b1;
        end else begin
            if (position_q != '0) pos_step = position_q - 1'b1;
        end
    end

    // Command FSM: accepts home/load in IDLE and times the chip-select / increment pulse train
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            cnt         <= '0;
            steps       <= '0;
            position_q  <= '0;
            store_q     <= 1'b0;
            homing      <= 1'b0;
            home_pend   <= (HOME_ON_RESET != 0);
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            pos_valid_q <= 1'b0;
            cs_n_q      <= 1'b1;
            inc_n_q     <= 1'b1;
            u_d_q       <= 1'b0;
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            case (state)
                IDLE: begin
                    if (home_pend || bus.home) begin
                        home_pend <= 1'b0;
                        homing    <= 1'b1;
                        store_q   <= 1'b0;
                        steps     <= MAX_POS;
                        u_d_q     <= 1'b0;
                        busy_q    <= 1'b1;
                        cs_n_q    <= 1'b0;
                        cnt       <= SETUP_LD;
                        state     <= SETUP;
                    end else if (bus.load) begin
                        if (({1'b0, bus.target} >= TAPS_W) || !pos_valid_q) begin
                            err_q <= 1'b1;
                        end else if ((bus.target == position_q) && !bus.store) begin
                            done_q <= 1'b1;
                        end else begin
                            homing  <= 1'b0;
                            store_q <= bus.store;
                            steps   <= (bus.target > position_q) ? bus.target - position_q
                                                                 : position_q - bus.target;
                            u_d_q   <= (bus.target > position_q);
                            busy_q  <= 1'b1;
                            cs_n_q  <= 1'b0;
                            cnt     <= SETUP_LD;
                            state   <= SETUP;
                        end
                    end
                end
                SETUP, STEP_HI: begin
                    if (cnt != '0) begin
                        cnt <= cnt - 16'd1;
                    end else if (steps != '0) begin
                        // STEP_LO entry: the only place inc_n may fall while selected
                        inc_n_q    <= 1'b0;
                        steps      <= steps - 1'b1;
                        position_q <= pos_step;
                        cnt        <= PULSE_LD;
                        state      <= STEP_LO;
                    end else begin
                        cs_n_q <= 1'b1;
                        state  <= DESEL;
                    end
                end
                STEP_LO: begin
                    if (cnt != '0) begin
                        cnt <= cnt - 16'd1;
                    end else if ((steps != '0) || store_q) begin
                        inc_n_q <= 1'b1;
                        cnt     <= PULSE_LD;
                        state   <= STEP_HI;
                    end else begin
                        cs_n_q <= 1'b1;
                        state  <= DESEL;
                    end
                end
                DESEL: begin
                    inc_n_q <= 1'b1;
                    cnt     <= DESEL_LD;
                    state   <= RECOVER;
                end
                RECOVER: begin
                    if (cnt != '0) begin
                        cnt <= cnt - 16'd1;
                    end else begin
                        done_q <= 1'b1;
                        busy_q <= 1'b0;
                        if (homing) pos_valid_q <= 1'b1;
                        state  <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_digpot_seq.sv
// tb/tb_digpot_seq.sv - randomized and directed bench for digpot_seq against a timing-formula model
module tb_digpot_seq;
    localparam int TAPS = 100;
    localparam int P    = 2;
    localparam int C    = 2;
    localparam int D    = 3;

    logic clk;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;
    int   nprint = 0;
    int   fall_cnt = 0;
    bit   chk_en = 0;

    digpot_seq_if #(.WIDTH(7)) bus ();
    digpot_seq_if #(.WIDTH(7)) bus2 ();

    digpot_seq #(.TAPS(TAPS), .WIDTH(7), .PULSE_CYC(P), .CS_SETUP(C), .DESEL_CYC(D),
                 .HOME_ON_RESET(1)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
    digpot_seq #(.TAPS(TAPS), .WIDTH(7), .PULSE_CYC(P), .CS_SETUP(C), .DESEL_CYC(D),
                 .HOME_ON_RESET(0)) dut2 (.clk(clk), .rst_n(rst_n), .bus(bus2));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge bus.inc_n) if (bus.cs_n == 1'b0) fall_cnt++;

    // Model: a command is a pulse train whose shape follows from N, direction and store
    bit m_active = 0, m_dir = 0, m_store = 0, m_home = 0, m_pend = 1;
    int m_k = 0, m_n = 0, m_l = 0, m_lat = 0, m_pos0 = 0;
    bit e_cs = 1, e_inc = 1, e_ud = 0, e_busy = 0, e_done = 0, e_err = 0, e_pv = 0;
    int e_pos = 0;

    task automatic m_start(input int n, input bit dir, input bit st, input bit hm, input int cur);
        m_active = 1; m_k = 1; m_n = n; m_dir = dir; m_store = st; m_home = hm; m_pos0 = cur;
        m_l   = C + (st ? 2 * n * P : (2 * n - 1) * P);
        m_lat = m_l + 2 + D;
        e_ud  = dir;
    endtask

    always @(posedge clk or negedge rst_n) begin : mdl
        int cur, t, f, off;
        bit idle, zdone;
        if (!rst_n) begin
            m_active = 0; m_pend = 1; m_k = 0;
            e_cs = 1; e_inc = 1; e_ud = 0; e_busy = 0; e_done = 0; e_err = 0; e_pv = 0; e_pos = 0;
        end else begin
            cur = e_pos; idle = !m_active || (m_k == m_lat); e_err = 0; zdone = 0;
            if (idle) begin
                m_active = 0;
                t = int'(bus.target);
                if (m_pend || bus.home) begin
                    m_pend = 0;
                    m_start(TAPS - 1, 0, 0, 1, cur);
                end else if (bus.load) begin
                    if (t >= TAPS || !e_pv) e_err = 1;
                    else if (t == cur && !bus.store) zdone = 1;
                    else m_start((t > cur) ? t - cur : cur - t, t > cur, bus.store, 0, cur);
                end
            end else begin
                m_k++;
            end
            if (m_active) begin
                e_cs  = !(m_k <= m_l);
                off   = m_k - C - 1;
                f     = (off < 0) ? 0 : off / (2 * P) + 1;
                if (f > m_n) f = m_n;
                e_inc = !((off >= 0 && off / (2 * P) < m_n && off % (2 * P) < P) ||
                          (!m_store && m_k == m_l + 1));
                e_pos = m_dir ? m_pos0 + f : m_pos0 - f;
                if (e_pos < 0) e_pos = 0;
                if (e_pos > TAPS - 1) e_pos = TAPS - 1;
                e_busy = (m_k < m_lat);
                e_done = (m_k == m_lat);
                if (e_done && m_home) e_pv = 1;
            end else begin
                e_cs = 1; e_inc = 1; e_busy = 0; e_done = zdone;
            end
        end
    end

    // Per-cycle comparison of every output against the model
    always @(negedge clk) begin
        if (chk_en) begin
            checks++;
            if (bus.cs_n !== e_cs || bus.inc_n !== e_inc || bus.u_d !== e_ud || bus.busy !== e_busy ||
                bus.done !== e_done || bus.err !== e_err || int'(bus.position) != e_pos ||
                bus.pos_valid !== e_pv) begin
                errors++;
                if (nprint < 20) begin
                    nprint++;
                    $display("FAIL model_cycle t=%0t got cs_n=%b inc_n=%b u_d=%b busy=%b done=%b err=%b pos=%0d pv=%b expected cs_n=%b inc_n=%b u_d=%b busy=%b done=%b err=%b pos=%0d pv=%b",
                             $time, bus.cs_n, bus.inc_n, bus.u_d, bus.busy, bus.done, bus.err,
                             bus.position, bus.pos_valid, e_cs, e_inc, e_ud, e_busy, e_done, e_err,
                             e_pos, e_pv);
                end
            end
        end
    end

    task automatic chk(input string name, input longint got, input longint exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", name, got, exp);
        end
    endtask

    task automatic go(input int t, input bit st, input bit ld, input bit hm, input int xk, input int xt,
                      input int budget, output int lat, output int cs_cyc, output int falls,
                      output bit inc_rise, output bit got_err);
        int f0;
        bit prev_cs;
        f0 = fall_cnt; lat = -1; cs_cyc = 0; inc_rise = 1; got_err = 0; prev_cs = 1;
        @(negedge clk);
        bus.target = 7'(t); bus.store = st; bus.load = ld; bus.home = hm;
        for (int k = 1; k <= budget; k++) begin
            @(posedge clk); #1;
            if (k == 1 || k == xk + 1) begin bus.load = 0; bus.home = 0; end
            if (k == xk) begin bus.load = 1; bus.target = 7'(xt); end
            if (!bus.cs_n) cs_cyc++;
            if (!prev_cs && bus.cs_n) inc_rise = bus.inc_n;
            prev_cs = bus.cs_n;
            if (bus.done || bus.err) begin lat = k; got_err = bus.err; break; end
        end
        falls = fall_cnt - f0;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1);
    end

    initial begin
        int lat, cs_cyc, falls, n;
        bit inc_rise, got_err;
        rst_n = 0;
        bus.target = 0; bus.load = 0; bus.store = 0; bus.home = 0;
        bus2.target = 0; bus2.load = 0; bus2.store = 0; bus2.home = 0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_cs_n", bus.cs_n, 1);
        chk("reset_inc_n", bus.inc_n, 1);
        chk("reset_u_d", bus.u_d, 0);
        chk("reset_busy_done_err", {bus.busy, bus.done, bus.err}, 0);
        chk("reset_position", bus.position, 0);
        chk("reset_pos_valid", bus.pos_valid, 0);
        chk_en = 1;
        @(negedge clk);
        rst_n = 1;

        go(0, 0, 0, 0, 0, 0, 600, lat, cs_cyc, falls, inc_rise, got_err);
        chk("home_falls", falls, 99);
        chk("home_timeout", lat > 0, 1);
        chk("home_position", bus.position, 0);
        chk("home_pos_valid", bus.pos_valid, 1);

        @(negedge clk); bus2.target = 5; bus2.load = 1;
        @(posedge clk); #1; bus2.load = 0;
        chk("nohome_err", bus2.err, 1);
        chk("nohome_cs_n", bus2.cs_n, 1);
        chk("nohome_busy", bus2.busy, 0);
        @(posedge clk); #1;
        chk("nohome_err_pulse", bus2.err, 0);

        go(5, 0, 1, 0, 0, 0, 100, lat, cs_cyc, falls, inc_rise, got_err);
        chk("up5_latency", lat, 25);
        chk("up5_cs_low", cs_cyc, 20);
        chk("up5_falls", falls, 5);
        chk("up5_inc_at_cs_rise", inc_rise, 0);
        chk("up5_position", bus.position, 5);
        chk("up5_u_d", bus.u_d, 1);

        go(3, 1, 1, 0, 0, 0, 100, lat, cs_cyc, falls, inc_rise, got_err);
        chk("down3_store_latency", lat, 15);
        chk("down3_store_cs_low", cs_cyc, 10);
        chk("down3_store_falls", falls, 2);
        chk("down3_store_inc_at_cs_rise", inc_rise, 1);
        chk("down3_store_position", bus.position, 3);
        chk("down3_store_u_d", bus.u_d, 0);

        go(100, 0, 1, 0, 0, 0, 20, lat, cs_cyc, falls, inc_rise, got_err);
        chk("bad_target_err", got_err, 1);
        chk("bad_target_latency", lat, 1);
        chk("bad_target_cs_low", cs_cyc, 0);

        go(3, 0, 1, 0, 0, 0, 20, lat, cs_cyc, falls, inc_rise, got_err);
        chk("same_target_done_latency", lat, 1);
        chk("same_target_no_err", got_err, 0);
        chk("same_target_cs_low", cs_cyc, 0);

        go(50, 0, 1, 0, 10, 10, 400, lat, cs_cyc, falls, inc_rise, got_err);
        chk("busy_load_ignored_latency", lat, 193);
        chk("busy_load_ignored_falls", falls, 47);
        chk("busy_load_ignored_position", bus.position, 50);

        go(20, 0, 1, 1, 0, 0, 600, lat, cs_cyc, falls, inc_rise, got_err);
        chk("home_wins_latency", lat, 401);
        chk("home_wins_falls", falls, 99);
        chk("home_wins_position", bus.position, 0);

        @(negedge clk); bus.target = 60; bus.store = 0; bus.load = 1;
        @(posedge clk); #1; bus.load = 0;
        n = 0;
        while (bus.inc_n && n < 40) begin @(posedge clk); #1; n++; end
        chk("reach_step_lo", bus.inc_n, 0);
        #2; rst_n = 0; #1;
        chk("async_cs_n", bus.cs_n, 1);
        chk("async_inc_n", bus.inc_n, 1);
        chk("async_busy", bus.busy, 0);
        chk("async_pos_valid", bus.pos_valid, 0);
        repeat (2) @(posedge clk);
        @(negedge clk); rst_n = 1;
        go(0, 0, 0, 0, 0, 0, 600, lat, cs_cyc, falls, inc_rise, got_err);
        chk("rehome_falls", falls, 99);
        chk("rehome_pos_valid", bus.pos_valid, 1);

        for (int c = 0; c < 12000; c++) begin
            @(negedge clk);
            bus.load  = ($urandom_range(23) == 0);
            bus.home  = ($urandom_range(299) == 0);
            bus.store = 1'($urandom_range(1));
            if ($urandom_range(7) == 0) bus.target = bus.position;
            else if ($urandom_range(3) == 0) bus.target = 7'($urandom_range(127));
            else bus.target = 7'($urandom_range(99));
        end
        @(negedge clk);
        bus.load = 0; bus.home = 0; bus.store = 0;
        repeat (450) @(posedge clk);
        chk("final_idle", bus.busy, 0);
        @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
